// File: rtl/rans_pkg.sv
// Shared types and constants for the byte-oriented rANS decoder.
package rans_pkg;
  localparam int RESOLUTION   = 10;
  localparam int SYMBOL_WIDTH = 8;
  localparam int STATE_WIDTH  = 32;
  localparam int M            = 1 << RESOLUTION;
  localparam int NSYM         = 1 << SYMBOL_WIDTH;

  typedef logic [STATE_WIDTH-1:0]  state_t;
  typedef logic [SYMBOL_WIDTH-1:0] sym_t;
  typedef logic [RESOLUTION:0]     freq_t;
  typedef logic [RESOLUTION-1:0]   cum_t;

  // Lower bound of the normalised state interval; also the encoder's initial state.
  localparam state_t RANS_L = state_t'(1) << (STATE_WIDTH - 9);

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_LOOKUP, S_FETCH, S_EMIT, S_RENORM, S_DONE
  } rans_dec_state_e;
endpackage

// File: rtl/rans_dec_tables.sv
// Decoder tables: slot->symbol map and per-symbol freq/cum, both 1-cycle synchronous read.
module rans_dec_tables
  import rans_pkg::*;
(
  input  logic  clk_i,
  input  logic  slot_we_i,
  input  cum_t  slot_waddr_i,
  input  sym_t  slot_wsym_i,
  input  logic  slot_re_i,
  input  cum_t  slot_raddr_i,
  output sym_t  slot_sym_o,
  input  logic  sym_we_i,
  input  sym_t  sym_waddr_i,
  input  freq_t freq_i,
  input  cum_t  cum_i,
  input  logic  sym_re_i,
  input  sym_t  sym_raddr_i,
  output freq_t freq_o,
  output cum_t  cum_o
);
  sym_t  slot_mem [M];
  freq_t freq_mem [NSYM];
  cum_t  cum_mem  [NSYM];

  // Read ports only update when enabled so the looked-up entry is held through EMIT.
  always_ff @(posedge clk_i) begin
    if (slot_we_i) slot_mem[slot_waddr_i] <= slot_wsym_i;
    if (slot_re_i) slot_sym_o <= slot_mem[slot_raddr_i];
    if (sym_we_i) begin
      freq_mem[sym_waddr_i] <= freq_i;
      cum_mem[sym_waddr_i]  <= cum_i;
    end
    if (sym_re_i) begin
      freq_o <= freq_mem[sym_raddr_i];
      cum_o  <= cum_mem[sym_raddr_i];
    end
  end
endmodule

// File: rtl/rans_decoder.sv
// rANS decoder: consumes the encoder byte stream in reverse, emits symbols with backpressure.
// Optional final-state check enabled by defining RANS_DEC_FINAL_CHECK_EN.
module rans_decoder
  import rans_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [31:0]             sym_count,
  input  logic                    tbl_sym_we,
  input  logic [SYMBOL_WIDTH-1:0] tbl_sym,
  input  logic [RESOLUTION:0]     tbl_freq,
  input  logic [RESOLUTION-1:0]   tbl_cum,
  input  logic                    tbl_slot_we,
  input  logic [RESOLUTION-1:0]   tbl_slot,
  input  logic [SYMBOL_WIDTH-1:0] tbl_slot_sym,
  input  logic                    in_valid,
  input  logic [7:0]              in_data,
  output logic                    in_ready,
  output logic                    sym_valid,
  output logic [SYMBOL_WIDTH-1:0] sym_data,
  input  logic                    sym_ready,
  output logic                    busy,
  output logic                    done,
  output logic                    err
);
  rans_dec_state_e st_q, st_d;
  state_t          state_q, state_d;
  logic [31:0]     cnt_q, cnt_d;
  logic [1:0]      bcnt_q, bcnt_d;
  sym_t            sym_q, sym_d;

  sym_t  slot_sym;
  freq_t freq_rd;
  cum_t  cum_rd;
  cum_t  slot;
  state_t dec_x, shift_x;
  logic [31:0] cnt_m1;

  wire idle = (st_q == S_IDLE);

  rans_dec_tables u_tables (
    .clk_i        (clk),
    .slot_we_i    (tbl_slot_we && idle),
    .slot_waddr_i (tbl_slot),
    .slot_wsym_i  (tbl_slot_sym),
    .slot_re_i    (st_q == S_LOOKUP),
    .slot_raddr_i (slot),
    .slot_sym_o   (slot_sym),
    .sym_we_i     (tbl_sym_we && idle),
    .sym_waddr_i  (tbl_sym),
    .freq_i       (tbl_freq),
    .cum_i        (tbl_cum),
    .sym_re_i     (st_q == S_FETCH),
    .sym_raddr_i  (slot_sym),
    .freq_o       (freq_rd),
    .cum_o        (cum_rd)
  );

  assign slot    = state_q[RESOLUTION-1:0];
  assign dec_x   = state_t'(freq_rd) * (state_q >> RESOLUTION) + state_t'(slot) - state_t'(cum_rd);
  assign shift_x = {state_q[STATE_WIDTH-9:0], in_data};
  assign cnt_m1  = cnt_q - 32'd1;

  always_comb begin
    st_d    = st_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    bcnt_d  = bcnt_q;
    sym_d   = sym_q;
    case (st_q)
      S_IDLE: if (start) begin
        cnt_d   = sym_count;
        state_d = '0;
        bcnt_d  = '0;
        st_d    = S_INIT;
      end
      S_INIT: if (in_valid) begin
        state_d = shift_x;
        bcnt_d  = bcnt_q + 2'd1;
        if (bcnt_q == 2'd3) st_d = (cnt_q == 32'd0) ? S_DONE : S_LOOKUP;
      end
      S_LOOKUP: st_d = S_FETCH;
      S_FETCH: begin
        sym_d = slot_sym;
        st_d  = S_EMIT;
      end
      // Skip RENORM entirely when the new state is already normalised.
      S_EMIT: if (sym_ready) begin
        state_d = dec_x;
        cnt_d   = cnt_m1;
        if (dec_x < RANS_L) st_d = S_RENORM;
        else                st_d = (cnt_m1 == 32'd0) ? S_DONE : S_LOOKUP;
      end
      S_RENORM: if (in_valid) begin
        state_d = shift_x;
        if (shift_x >= RANS_L) st_d = (cnt_q == 32'd0) ? S_DONE : S_LOOKUP;
      end
      S_DONE:  st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q    <= S_IDLE;
      state_q <= '0;
      cnt_q   <= '0;
      bcnt_q  <= '0;
      sym_q   <= '0;
    end else begin
      st_q    <= st_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bcnt_q  <= bcnt_d;
      sym_q   <= sym_d;
    end
  end

  assign in_ready  = (st_q == S_INIT) || (st_q == S_RENORM);
  assign sym_valid = (st_q == S_EMIT);
  assign sym_data  = sym_q;
  assign busy      = !idle;
  assign done      = (st_q == S_DONE);

`ifdef RANS_DEC_FINAL_CHECK_EN
  assign err = (st_q == S_DONE) && (state_q != RANS_L);
`else
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_rans_decoder.sv
// Self-checking bench for rans_decoder: reference rANS encoder/decoder model, random tables and streams.
module tb_rans_decoder;
  import rans_pkg::*;
  typedef logic [7:0] bq_t[$];
  localparam longint LL = 64'h0080_0000;

  logic clk = 1'b0;
  logic rst, start, tbl_sym_we, tbl_slot_we, in_valid, sym_ready;
  logic [31:0] sym_count;
  logic [7:0] tbl_sym, tbl_slot_sym, in_data;
  logic [10:0] tbl_freq;
  logic [9:0] tbl_cum, tbl_slot;
  logic in_ready, sym_valid, busy, done, err;
  logic [7:0] sym_data;

  int n_cmp = 0, n_bad = 0;
  int m_freq[256], m_cum[256], m_slot[1024];

  rans_decoder dut (
    .clk(clk), .rst(rst), .start(start), .sym_count(sym_count),
    .tbl_sym_we(tbl_sym_we), .tbl_sym(tbl_sym), .tbl_freq(tbl_freq), .tbl_cum(tbl_cum),
    .tbl_slot_we(tbl_slot_we), .tbl_slot(tbl_slot), .tbl_slot_sym(tbl_slot_sym),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .sym_valid(sym_valid), .sym_data(sym_data), .sym_ready(sym_ready),
    .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic put_sym(input int s, input int f, input int c);
    @(negedge clk);
    tbl_sym_we = 1'b1; tbl_sym = 8'(s); tbl_freq = 11'(f); tbl_cum = 10'(c);
    m_freq[s] = f; m_cum[s] = c;
    @(negedge clk);
    tbl_sym_we = 1'b0;
  endtask

  task automatic put_slots(input int lo, input int hi, input int s);
    @(negedge clk);
    tbl_slot_we = 1'b1; tbl_slot_sym = 8'(s);
    for (int i = lo; i <= hi; i++) begin
      tbl_slot = 10'(i); m_slot[i] = s;
      @(negedge clk);
    end
    tbl_slot_we = 1'b0;
  endtask

  // Reference decode straight from the rANS recurrence.
  function automatic void model(input bq_t bq, input int cnt, output bq_t syms,
                                output longint fs, output int used);
    longint x; int p, r, s;
    x = 0; p = 0; syms = {};
    for (int i = 0; i < 4 && p < bq.size(); i++) begin x = x * 256 + longint'(bq[p]); p++; end
    for (int i = 0; i < cnt; i++) begin
      r = int'(x % 1024); s = m_slot[r];
      syms.push_back(8'(s));
      x = longint'(m_freq[s]) * (x / 1024) + r - m_cum[s];
      while (x < LL && p < bq.size()) begin x = x * 256 + longint'(bq[p]); p++; end
    end
    fs = x; used = p;
  endfunction

  // Reference encoder; returns the stream already in decoder consumption order.
  function automatic bq_t encode(input bq_t msg);
    longint x; int s, f; bq_t out;
    x = LL; out = {};
    for (int i = msg.size() - 1; i >= 0; i--) begin
      s = int'(msg[i]); f = m_freq[s];
      while (x >= ((LL >> 10) << 8) * f) begin out.push_front(8'(x)); x = x >> 8; end
      x = (x / f) * 1024 + (x % f) + m_cum[s];
    end
    for (int k = 0; k < 4; k++) begin out.push_front(8'(x)); x = x >> 8; end
    return out;
  endfunction

  function automatic bit same_q(input bq_t a, input bq_t b);
    if (a.size() != b.size()) return 1'b0;
    foreach (a[i]) if (a[i] !== b[i]) return 1'b0;
    return 1'b1;
  endfunction

  task automatic run_decode(input bq_t bq, input int cnt, input int in_mode, input int sk_mode,
                            output bq_t syms, output logic e, output int used,
                            output int first_lat, output int done_cyc, output bit fin);
    syms = {}; used = 0; fin = 1'b0; first_lat = -1; done_cyc = -1; e = 1'b0;
    @(negedge clk); start = 1'b1; sym_count = cnt;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc < 3000 && !fin; cyc++) begin
      in_valid  = (used < bq.size()) && (in_mode == 0 || cyc[0]);
      in_data   = in_valid ? bq[used] : 8'h00;
      sym_ready = (sk_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (sym_valid && first_lat < 0) first_lat = cyc;
      if (sym_valid && sym_ready) syms.push_back(sym_data);
      if (in_valid && in_ready) used++;
      if (done) begin fin = 1'b1; e = err; done_cyc = cyc; end
      @(negedge clk);
    end
    in_valid = 1'b0; sym_ready = 1'b0;
  endtask

  function automatic logic exp_err(input longint fs);
`ifdef RANS_DEC_FINAL_CHECK_EN
    return fs != LL;
`else
    return 1'b0;
`endif
  endfunction

  task automatic load_two();
    put_sym(8'h41, 512, 0); put_sym(8'h42, 512, 512);
    put_slots(0, 511, 8'h41); put_slots(512, 1023, 8'h42);
  endtask

  task automatic load_random();
    int nsym, rem, f, c, s;
    nsym = $urandom_range(2, 6); rem = 1024; c = 0; s = $urandom_range(0, 255);
    for (int k = 0; k < nsym; k++) begin
      f = (k == nsym - 1) ? rem : $urandom_range(1, rem - (nsym - 1 - k));
      if (k != nsym - 1 && f > 600) f = 600;
      put_sym((s + 37 * k) % 256, f, c);
      put_slots(c, c + f - 1, (s + 37 * k) % 256);
      c += f; rem -= f;
    end
  endtask

  function automatic bq_t rand_msg(input int n);
    bq_t m; int s;
    m = {};
    for (int i = 0; i < n; i++) begin
      s = m_slot[$urandom_range(0, 1023)];
      m.push_back(8'(s));
    end
    return m;
  endfunction

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({in_ready, sym_valid, busy, done, err, sym_data} !== 13'h0) begin
      n_bad++; $display("FAIL reset_outputs got %h want 0", {in_ready, sym_valid, busy, done, err, sym_data});
    end
    n_cmp++;
    if (dut.state_q !== 32'h0) begin n_bad++; $display("FAIL reset_state got %h want 0", dut.state_q); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_symbol();
    bq_t bq, syms, exp; logic e; int used, fl, dc, mu; bit fin; longint fs;
    put_sym(8'h41, 1024, 0); put_slots(0, 1023, 8'h41);
    bq = '{8'h00, 8'h80, 8'h00, 8'h00};
    model(bq, 5, exp, fs, mu);
    run_decode(bq, 5, 0, 0, syms, e, used, fl, dc, fin);
    n_cmp++; if (!fin) begin n_bad++; $display("FAIL single_timeout got 0 want 1"); end
    n_cmp++; if (!same_q(syms, exp)) begin n_bad++; $display("FAIL single_syms got %0d syms want %0d", syms.size(), exp.size()); end
    n_cmp++; if (used !== 4) begin n_bad++; $display("FAIL single_bytes got %0d want 4", used); end
    n_cmp++; if (e !== exp_err(fs)) begin n_bad++; $display("FAIL single_err got %b want %b", e, exp_err(fs)); end
    n_cmp++; if (fl !== 7) begin n_bad++; $display("FAIL first_latency got %0d want 7", fl); end
    n_cmp++; if (dc !== 20) begin n_bad++; $display("FAIL done_cycle got %0d want 20", dc); end
  endtask

  task automatic test_two_symbol();
    bq_t bq, syms, exp; logic e; int used, fl, dc, mu; bit fin; longint fs;
    load_two();
    bq = '{8'h00, 8'h80, 8'h02, 8'h00, 8'h00};
    model(bq, 1, exp, fs, mu);
    run_decode(bq, 1, 0, 0, syms, e, used, fl, dc, fin);
    n_cmp++; if (!same_q(syms, exp) || syms.size() != 1 || syms[0] !== 8'h42) begin
      n_bad++; $display("FAIL two_syms got %0d syms want one 42", syms.size()); end
    n_cmp++; if (dut.state_q !== 32'(fs)) begin n_bad++; $display("FAIL two_state got %h want %h", dut.state_q, 32'(fs)); end
    n_cmp++; if (used !== 5) begin n_bad++; $display("FAIL two_bytes got %0d want 5", used); end
    n_cmp++; if (e !== exp_err(fs)) begin n_bad++; $display("FAIL two_err got %b want %b", e, exp_err(fs)); end
  endtask

  task automatic test_backpressure();
    bq_t bq, syms, msg; int used, hold; bit fin; logic [7:0] d0; logic [31:0] s0;
    load_two();
    msg = '{8'h42, 8'h41, 8'h42}; bq = encode(msg);
    syms = {}; used = 0; hold = 0; fin = 1'b0; d0 = '0; s0 = '0;
    @(negedge clk); start = 1'b1; sym_count = msg.size();
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc < 500 && !fin; cyc++) begin
      in_valid = used < bq.size(); in_data = in_valid ? bq[used] : 8'h00;
      sym_ready = (hold >= 10);
      if (sym_valid && syms.size() == 0 && hold < 10) begin
        if (hold == 0) begin d0 = sym_data; s0 = dut.state_q; end
        else begin
          n_cmp++; if (sym_data !== d0 || dut.state_q !== s0) begin
            n_bad++; $display("FAIL bp_hold got %h/%h want %h/%h", sym_data, dut.state_q, d0, s0); end
        end
        hold++;
      end
      if (sym_valid && sym_ready) syms.push_back(sym_data);
      if (in_valid && in_ready) used++;
      if (done) fin = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0; sym_ready = 1'b0;
    n_cmp++; if (hold !== 10) begin n_bad++; $display("FAIL bp_valid_held got %0d want 10", hold); end
    n_cmp++; if (!fin || !same_q(syms, msg)) begin n_bad++; $display("FAIL bp_syms got %0d want %0d", syms.size(), msg.size()); end
  endtask

  task automatic test_in_stall(input int rounds);
    bq_t bq, msg, s0, s1; logic e0, e1; int u0, u1, fl, dc; bit f0, f1;
    for (int r = 0; r < rounds; r++) begin
      load_random();
      msg = rand_msg(24); bq = encode(msg);
      run_decode(bq, msg.size(), 0, 0, s0, e0, u0, fl, dc, f0);
      run_decode(bq, msg.size(), 1, 1, s1, e1, u1, fl, dc, f1);
      n_cmp++; if (!f0 || !same_q(s0, msg)) begin n_bad++; $display("FAIL rand_nostall r%0d got %0d syms want %0d", r, s0.size(), msg.size()); end
      n_cmp++; if (!f1 || !same_q(s1, s0)) begin n_bad++; $display("FAIL rand_stall r%0d got %0d syms want %0d", r, s1.size(), s0.size()); end
      n_cmp++; if (u0 !== bq.size() || u1 !== bq.size()) begin n_bad++; $display("FAIL rand_bytes r%0d got %0d/%0d want %0d", r, u0, u1, bq.size()); end
      n_cmp++; if (e0 !== 1'b0 || e1 !== 1'b0) begin n_bad++; $display("FAIL rand_err r%0d got %b/%b want 0", r, e0, e1); end
    end
  endtask

  task automatic test_reset_mid();
    bq_t bq, syms; logic e; int used, fl, dc; bit fin, seen, got;
    load_two();
    bq = '{8'h00, 8'h80, 8'h02, 8'h00};
    used = 0; seen = 1'b0; got = 1'b0;
    @(negedge clk); start = 1'b1; sym_count = 1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc < 100 && !got; cyc++) begin
      in_valid = used < bq.size(); in_data = in_valid ? bq[used] : 8'h00;
      sym_ready = 1'b1;
      if (seen && in_ready && used == 4) got = 1'b1;
      else begin
        if (sym_valid) seen = 1'b1;
        if (in_valid && in_ready) used++;
        @(negedge clk);
      end
    end
    in_valid = 1'b0; sym_ready = 1'b0;
    n_cmp++; if (!got) begin n_bad++; $display("FAIL rst_reach_renorm got 0 want 1"); end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({in_ready, sym_valid, busy, done, err, sym_data} !== 13'h0) begin
      n_bad++; $display("FAIL rst_mid_outputs got %h want 0", {in_ready, sym_valid, busy, done, err, sym_data});
    end
    rst = 1'b0;
    bq.push_back(8'h00);
    run_decode(bq, 1, 0, 0, syms, e, used, fl, dc, fin);
    n_cmp++; if (!fin || syms.size() != 1 || syms[0] !== 8'h42) begin n_bad++; $display("FAIL rst_restart got %0d syms want one 42", syms.size()); end
    n_cmp++; if (dut.state_q !== 32'h4000_0000) begin n_bad++; $display("FAIL rst_restart_state got %h want 40000000", dut.state_q); end
  endtask

  task automatic test_final_check();
    bq_t bq, syms, exp; logic e; int used, fl, dc, mu; bit fin; longint fs;
    put_sym(8'h41, 1024, 0); put_slots(0, 1023, 8'h41);
    bq = '{8'h00, 8'h80, 8'h00, 8'h01};
    model(bq, 1, exp, fs, mu);
    run_decode(bq, 1, 0, 0, syms, e, used, fl, dc, fin);
    n_cmp++; if (!fin || e !== exp_err(fs)) begin n_bad++; $display("FAIL final_err got %b want %b", e, exp_err(fs)); end
    n_cmp++; if (!same_q(syms, exp)) begin n_bad++; $display("FAIL final_syms got %0d want %0d", syms.size(), exp.size()); end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0; sym_count = '0; tbl_sym_we = 1'b0; tbl_slot_we = 1'b0;
    tbl_sym = '0; tbl_freq = '0; tbl_cum = '0; tbl_slot = '0; tbl_slot_sym = '0;
    in_valid = 1'b0; in_data = '0; sym_ready = 1'b0;
    test_reset();
    test_single_symbol();
    test_two_symbol();
    test_backpressure();
    test_in_stall(3);
    test_reset_mid();
    test_final_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
